// File: rtl/fread_arbiter_if.sv
// Bundle of the requester-side and fread-core-side signals of fread_arbiter.
// The master modport is the arbiter itself; the slave modport is everything
// around it (requesters plus the spi_dev_fread core).
interface fread_arbiter_if #(
    parameter int N_REQ = 2
);
    // Requester side
    logic [32*N_REQ-1:0] rq_file_id;
    logic [32*N_REQ-1:0] rq_offset;
    logic [11*N_REQ-1:0] rq_len;
    logic [N_REQ-1:0]    rq_valid;
    logic [N_REQ-1:0]    rq_done;
    logic [N_REQ-1:0]    rq_err;
    logic [7:0]          rsp_data;
    logic [N_REQ-1:0]    rsp_valid;

    // fread core side
    logic [31:0]         fr_file_id;
    logic [31:0]         fr_offset;
    logic [10:0]         fr_len;
    logic                fr_valid;
    logic                fr_ready;
    logic [7:0]          fr_data;
    logic                fr_dvalid;

    // Status
    logic                busy;
    logic [2:0]          grant;

    modport master (
        input  rq_file_id, rq_offset, rq_len, rq_valid,
        input  fr_ready, fr_data, fr_dvalid,
        output rq_done, rq_err, rsp_data, rsp_valid,
        output fr_file_id, fr_offset, fr_len, fr_valid,
        output busy, grant
    );

    modport slave (
        output rq_file_id, rq_offset, rq_len, rq_valid,
        output fr_ready, fr_data, fr_dvalid,
        input  rq_done, rq_err, rsp_data, rsp_valid,
        input  fr_file_id, fr_offset, fr_len, fr_valid,
        input  busy, grant
    );
endinterface

// File: rtl/fread_arbiter.sv
// Round-robin arbiter sharing one spi_dev_fread request/stream port between
// N_REQ requesters. A granted request is captured, issued to the core, and the
// returned byte stream is steered to the granted requester until the requested
// byte count is reached. An optional watchdog aborts a stream that stalls.
module fread_arbiter #(
    parameter int N_REQ    = 2,
    parameter int TIMEOUT  = 0,
    parameter int TO_WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst,
    fread_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM,
        S_DONE,
        S_ABORT
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [31:0]         fid_q, fid_d;
    logic [31:0]         off_q, off_d;
    logic [10:0]         len_q, len_d;
    logic [11:0]         cnt_q, cnt_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    err_q, err_d;

    logic                hit;
    logic [2:0]          pick;
    logic [31:0]         fid_sel;
    logic [31:0]         off_sel;
    logic [10:0]         len_sel;
    logic [N_REQ-1:0]    grant_oh;

    // Round-robin search: first pending requester at grant+1, grant+2, ... (mod N_REQ).
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        hit  = 1'b0;
        pick = grant_q;
        for (int i = 1; i <= N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!hit && bus.rq_valid[j] && (((int'(grant_q) + i) % N_REQ) == j)) begin
                    hit  = 1'b1;
                    pick = 3'(j);
                end
            end
        end
    end

    // Select the picked requester's request fields and decode the current grant.
    always_comb begin
        fid_sel  = '0;
        off_sel  = '0;
        len_sel  = '0;
        grant_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (pick == 3'(j)) begin
                fid_sel = bus.rq_file_id[32*j +: 32];
                off_sel = bus.rq_offset[32*j +: 32];
                len_sel = bus.rq_len[11*j +: 11];
            end
            grant_oh[j] = (grant_q == 3'(j));
        end
    end

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        fid_d       = fid_q;
        off_d       = off_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wd_d        = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        done_d      = '0;
        err_d       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_ISSUE;
                    grant_d = pick;
                    fid_d   = fid_sel;
                    off_d   = off_sel;
                    len_d   = len_sel;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                // fr_valid is high for the whole ISSUE state; leave on handshake.
                if (bus.fr_ready) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (bus.fr_dvalid) begin
                    // A byte always wins over the watchdog and clears it.
                    cnt_d       = cnt_q + 12'd1;
                    rsp_valid_d = grant_oh;
                    rsp_data_d  = bus.fr_data;
                    if (cnt_d == {1'b0, len_q} + 12'd1) begin
                        state_d = S_DONE;
                    end
                end else if (TIMEOUT != 0) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == TO_WIDTH'(TIMEOUT)) begin
                        state_d = S_ABORT;
                        err_d   = grant_oh;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = grant_oh;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns to IDLE with all outputs low.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= 3'(N_REQ - 1);
            fid_q       <= '0;
            off_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            fid_q       <= fid_d;
            off_q       <= off_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.fr_valid   = (state_q == S_ISSUE);
    assign bus.fr_file_id = fid_q;
    assign bus.fr_offset  = off_q;
    assign bus.fr_len     = len_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rq_done    = done_q;
    assign bus.rq_err     = err_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.grant      = grant_q;

endmodule

// File: tb/tb_fread_arbiter.sv
// Directed bench for fread_arbiter with two requesters and a 100-cycle
// watchdog. Inputs change 1 time unit after the rising edge and outputs are
// sampled at that same point, so each sample reflects the preceding edge.
module tb_fread_arbiter;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    // Cumulative event counters maintained by the monitor below.
    int mon_strobe0 = 0;
    int mon_strobe1 = 0;
    int mon_done0   = 0;
    int mon_done1   = 0;
    int mon_err     = 0;

    fread_arbiter_if #(.N_REQ(2)) bus ();

    fread_arbiter #(
        .N_REQ   (2),
        .TIMEOUT (100),
        .TO_WIDTH(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes and pulses once per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (bus.rsp_valid[0] === 1'b1) mon_strobe0++;
        if (bus.rsp_valid[1] === 1'b1) mon_strobe1++;
        if (bus.rq_done[0] === 1'b1)   mon_done0++;
        if (bus.rq_done[1] === 1'b1)   mon_done1++;
        if (bus.rq_err !== 2'b00)      mon_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input int g);
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic set_req(input int r, input logic [31:0] fid, input logic [31:0] off,
                           input logic [10:0] len);
        if (r == 0) begin
            bus.rq_file_id[31:0] = fid;
            bus.rq_offset[31:0]  = off;
            bus.rq_len[10:0]     = len;
        end else begin
            bus.rq_file_id[63:32] = fid;
            bus.rq_offset[63:32]  = off;
            bus.rq_len[21:11]     = len;
        end
    endtask

    // Grant edge, ISSUE hold for ready_delay cycles, then the ready handshake.
    // After the grant the granted requester's fields are scrambled so that any
    // late capture shows up in fr_*.
    task automatic grant_issue(input int exp_g, input logic [31:0] fid, input logic [31:0] off,
                               input logic [10:0] len, input int ready_delay,
                               input logic [1:0] drop_mask);
        bit stable;
        tick();
        check("issue_fr_valid", 32'(bus.fr_valid), 32'd1);
        check("issue_grant", 32'(bus.grant), 32'(exp_g));
        check("issue_busy", 32'(bus.busy), 32'd1);
        check("issue_file_id", bus.fr_file_id, fid);
        check("issue_offset", bus.fr_offset, off);
        check("issue_len", 32'(bus.fr_len), 32'(len));
        bus.rq_valid = bus.rq_valid & ~drop_mask;
        set_req(exp_g, ~fid, ~off, ~len);
        stable = 1'b1;
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            if (bus.fr_valid !== 1'b1 || bus.fr_file_id !== fid ||
                bus.fr_offset !== off || bus.fr_len !== len) stable = 1'b0;
        end
        check("issue_hold_stable", 32'(stable), 32'd1);
        bus.fr_ready = 1'b1;
        tick();
        bus.fr_ready = 1'b0;
        check("stream_fr_valid_low", 32'(bus.fr_valid), 32'd0);
    endtask

    // Drive n consecutive bytes base, base+1, ... and check each forwarded byte.
    task automatic stream_bytes(input int exp_g, input int n, input logic [7:0] base);
        int good;
        logic [7:0] d;
        good = 0;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i);
            bus.fr_dvalid = 1'b1;
            bus.fr_data   = d;
            tick();
            if (bus.rsp_valid === oh(exp_g) && bus.rsp_data === d) good++;
        end
        bus.fr_dvalid = 1'b0;
        check("stream_good_bytes", 32'(good), 32'(n));
    endtask

    // Called right after the last byte: DONE state now, rq_done one cycle later.
    task automatic finish_done(input int exp_g);
        check("done_state_busy", 32'(bus.busy), 32'd1);
        check("done_not_yet", 32'(bus.rq_done), 32'd0);
        tick();
        check("done_pulse", 32'(bus.rq_done), 32'(oh(exp_g)));
        check("done_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int s0, s1, d0, d1, e0, k;
        bit seen, quiet;

        rst           = 1'b0;
        bus.rq_file_id = '0;
        bus.rq_offset  = '0;
        bus.rq_len     = '0;
        bus.rq_valid   = '0;
        bus.fr_ready   = 1'b0;
        bus.fr_data    = '0;
        bus.fr_dvalid  = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fr_valid", 32'(bus.fr_valid), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd1);
        check("rst_fr_file_id", bus.fr_file_id, 32'd0);
        rst = 1'b0;
        tick();

        // Single request on requester 0, 16 bytes
        s1 = mon_strobe1;
        d0 = mon_done0;
        set_req(0, 32'hDABBAD00, 32'h0000_1000, 11'h00F);
        bus.rq_valid = 2'b01;
        grant_issue(0, 32'hDABBAD00, 32'h0000_1000, 11'h00F, 0, 2'b01);
        stream_bytes(0, 16, 8'h00);
        finish_done(0);
        tick();
        check("single_done_once", 32'(mon_done0 - d0), 32'd1);
        check("single_no_req1_strobe", 32'(mon_strobe1 - s1), 32'd0);
        check("single_done_cleared", 32'(bus.rq_done), 32'd0);

        // Round robin after a fresh reset: grants 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s0 = mon_strobe0;
        s1 = mon_strobe1;
        d0 = mon_done0;
        d1 = mon_done1;
        set_req(0, 32'h1000_0000, 32'h100, 11'd3);
        set_req(1, 32'h1000_0001, 32'h101, 11'd3);
        bus.rq_valid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            set_req(r % 2, 32'h1000_0000 + 32'(r), 32'h100 + 32'(r), 11'd3);
            grant_issue(r % 2, 32'h1000_0000 + 32'(r), 32'h100 + 32'(r), 11'd3, 0, 2'b00);
            stream_bytes(r % 2, 4, 8'(8'h40 + 8'(16 * r)));
            finish_done(r % 2);
        end
        bus.rq_valid = 2'b00;
        tick();
        check("rr_strobes_req0", 32'(mon_strobe0 - s0), 32'd8);
        check("rr_strobes_req1", 32'(mon_strobe1 - s1), 32'd8);
        check("rr_done_req0", 32'(mon_done0 - d0), 32'd2);
        check("rr_done_req1", 32'(mon_done1 - d1), 32'd2);

        // Length boundary len=0, then stray bytes after completion
        set_req(0, 32'hA0A0_0000, 32'h0, 11'd0);
        bus.rq_valid = 2'b01;
        grant_issue(0, 32'hA0A0_0000, 32'h0, 11'd0, 0, 2'b01);
        stream_bytes(0, 1, 8'h77);
        finish_done(0);
        quiet = 1'b1;
        bus.fr_dvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.rsp_valid !== 2'b00) quiet = 1'b0;
        end
        bus.fr_dvalid = 1'b0;
        check("stray_after_done", 32'(quiet), 32'd1);

        // Length boundary len=0x7FF: 2048 bytes
        s0 = mon_strobe0;
        set_req(0, 32'hB0B0_0000, 32'h8000, 11'h7FF);
        bus.rq_valid = 2'b01;
        grant_issue(0, 32'hB0B0_0000, 32'h8000, 11'h7FF, 0, 2'b01);
        stream_bytes(0, 2048, 8'h00);
        finish_done(0);
        check("len_max_strobes", 32'(mon_strobe0 - s0), 32'd2048);

        // Watchdog: 5 of 8 bytes, then silence -> rq_err[1] 101 cycles after byte 5
        d1 = mon_done1;
        set_req(1, 32'hC0C0_0001, 32'h10, 11'd7);
        bus.rq_valid = 2'b10;
        grant_issue(1, 32'hC0C0_0001, 32'h10, 11'd7, 0, 2'b10);
        stream_bytes(1, 5, 8'h10);
        seen  = 1'b0;
        quiet = 1'b1;
        k     = 0;
        for (int j = 1; j <= 120 && !seen; j++) begin
            tick();
            if (bus.rsp_valid !== 2'b00) quiet = 1'b0;
            if (bus.rq_err !== 2'b00) begin
                seen = 1'b1;
                k    = j;
            end
        end
        check("wd_fire_cycle", 32'(k), 32'd100);
        check("wd_err_pulse", 32'(bus.rq_err), 32'b10);
        check("wd_abort_busy", 32'(bus.busy), 32'd1);
        check("wd_no_strobes", 32'(quiet), 32'd1);
        tick();
        check("wd_err_cleared", 32'(bus.rq_err), 32'd0);
        check("wd_idle_busy", 32'(bus.busy), 32'd0);
        check("wd_no_done", 32'(mon_done1 - d1), 32'd0);

        // Watchdog: a byte exactly at the firing cycle wins
        e0 = mon_err;
        set_req(0, 32'hC0C0_0000, 32'h20, 11'd7);
        bus.rq_valid = 2'b01;
        grant_issue(0, 32'hC0C0_0000, 32'h20, 11'd7, 0, 2'b01);
        stream_bytes(0, 5, 8'h20);
        repeat (99) tick();
        stream_bytes(0, 1, 8'h25);
        check("wd_race_no_err", 32'(bus.rq_err), 32'd0);
        check("wd_race_busy", 32'(bus.busy), 32'd1);
        stream_bytes(0, 2, 8'h26);
        finish_done(0);
        check("wd_race_no_err_total", 32'(mon_err - e0), 32'd0);

        // Reset mid-stream after 7 of 16 bytes on requester 1
        set_req(1, 32'hD0D0_0001, 32'h30, 11'h00F);
        bus.rq_valid = 2'b10;
        grant_issue(1, 32'hD0D0_0001, 32'h30, 11'h00F, 0, 2'b10);
        stream_bytes(1, 7, 8'h30);
        bus.fr_dvalid = 1'b1;
        bus.fr_data   = 8'h55;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("midrst_fr_valid", 32'(bus.fr_valid), 32'd0);
        check("midrst_fr_file_id", bus.fr_file_id, 32'd0);
        check("midrst_fr_offset", bus.fr_offset, 32'd0);
        check("midrst_fr_len", 32'(bus.fr_len), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_grant", 32'(bus.grant), 32'd1);
        tick();
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.rsp_valid !== 2'b00) quiet = 1'b0;
        end
        bus.fr_dvalid = 1'b0;
        check("post_rst_bytes_dropped", 32'(quiet), 32'd1);

        // Withdrawal and ISSUE hold: req1 withdraws while req0 waits 5 cycles for ready
        s1 = mon_strobe1;
        set_req(0, 32'hE0E0_0000, 32'h40, 11'd3);
        set_req(1, 32'hE0E0_0001, 32'h41, 11'd3);
        bus.rq_valid = 2'b11;
        grant_issue(0, 32'hE0E0_0000, 32'h40, 11'd3, 5, 2'b11);
        stream_bytes(0, 4, 8'h50);
        finish_done(0);
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy !== 1'b0) quiet = 1'b0;
        end
        check("withdraw_stays_idle", 32'(quiet), 32'd1);
        check("withdraw_grant", 32'(bus.grant), 32'd0);
        check("withdraw_no_req1_strobe", 32'(mon_strobe1 - s1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fread_arbiter.md
# fread_arbiter

Shares the single request/stream port of `spi_dev_fread` between `N_REQ` independent requesters, such as a RAM loader, a UART dumper and a configuration fetcher. It grants requesters round-robin and forwards one captured request to the fread core. It then steers the returned byte stream to the granted requester only, counts bytes until the request is complete, and releases the grant. A stall watchdog aborts a request whose stream dries up.

## Interface

Parameters:
- `N_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 0: number of idle cycles in STREAM before abort. 0 disables the watchdog.
- `TO_WIDTH`, default 24: width of the watchdog counter. Must satisfy `TIMEOUT < 2^TO_WIDTH`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rq_file_id`  in  32*N_REQ  file ID per requester; slice i = [32i+31:32i].
- `rq_offset`  in  32*N_REQ  file offset per requester.
- `rq_len`  in  11*N_REQ  byte count minus one per requester.
- `rq_valid`  in  N_REQ  request pending.
- `rq_done`  out  N_REQ  one-cycle pulse: all bytes delivered.
- `rq_err`  out  N_REQ  one-cycle pulse: request aborted by the watchdog.
- `rsp_data`  out  8  stream byte, shared by all requesters.
- `rsp_valid`  out  N_REQ  byte strobe for the granted requester only.
- `fr_file_id`  out  32  to `spi_dev_fread` `req_file_id`.
- `fr_offset`  out  32  to `req_offset`.
- `fr_len`  out  11  to `req_len`.
- `fr_valid`  out  1  to `req_valid`.
- `fr_ready`  in  1  from `req_ready`.
- `fr_data`  in  8  from `resp_data`.
- `fr_dvalid`  in  1  from `resp_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `grant`  out  3  index of the current or last granted requester.

## Operation

- States: IDLE, ISSUE, STREAM, DONE, ABORT.
- **IDLE**
  - Round-robin search starting at `grant+1` (mod `N_REQ`) for the first set bit of `rq_valid`.
  - On a hit, capture that requester's file ID, offset and length into `fr_*`, set `grant`, clear the byte counter, and go to ISSUE.
  - With no request pending, stay in IDLE.
- **ISSUE**
  - Drive `fr_valid=1`.
  - When `fr_valid & fr_ready`, drop `fr_valid` in the next cycle and go to STREAM.
  - `fr_*` stay stable throughout ISSUE.
- **STREAM**
  - Each `fr_dvalid` increments the 12-bit counter `cnt`.
  - It also drives `rsp_data <= fr_data` and sets `rsp_valid[grant]` for one cycle.
  - When the byte being accepted makes `cnt == fr_len+1`, go to DONE.
  - `fr_len=0` means 1 byte; `fr_len=0x7FF` means 2048 bytes. `cnt` is 12 bits so it never wraps.
- **DONE**: pulse `rq_done[grant]` for one cycle, then go to IDLE.
- **ABORT**: pulse `rq_err[grant]` for one cycle, then go to IDLE.
- **Watchdog** (`TIMEOUT != 0`)
  - The counter runs only in STREAM and clears on every `fr_dvalid`.
  - When it reaches `TIMEOUT`, go to ABORT.
  - If a byte arrives in the same cycle the counter would fire, the byte wins: it is forwarded and the counter clears.
- **Request capture**
  - The requester's `rq_*` fields are sampled only in IDLE, at grant time. Later changes are ignored until `rq_done` or `rq_err`.
  - Dropping `rq_valid` before grant withdraws the request.
  - Dropping `rq_valid` after grant has no effect.
- **Stray bytes**: `fr_dvalid` outside STREAM is dropped and `rsp_valid` stays 0.
- **Reset**
  - Reset takes effect at any time, including mid-stream, and returns to IDLE.
  - All outputs are 0 at reset: `rq_done`, `rq_err`, `rsp_valid`, `rsp_data`, `fr_*`, `busy`.
  - `grant` resets to `N_REQ-1`, so requester 0 has first priority.
  - Bytes still streamed by the core after reset are dropped.

## Timing

- Grant latency: request seen in IDLE at cycle t gives `fr_valid=1` at t+1.
- Back-to-back `fr_valid`/`fr_ready` in the first ISSUE cycle gives STREAM from t+2.
- Stream latency: `fr_dvalid` at cycle t gives `rsp_valid[grant]` and `rsp_data` at t+1. No throttling; the arbiter accepts one byte per cycle.
- Completion: the last byte accepted at t gives state DONE at t+1 (`rsp_valid` for that byte also at t+1) and the `rq_done` pulse at t+2; IDLE at t+2, new grant decision at t+3.
- Abort: watchdog fires at t gives the `rq_err` pulse at t+1 (ABORT state); IDLE at t+2.
- Minimum gap between two requests' `fr_valid` assertions: 3 cycles after the final byte.
- `busy` is registered and equals `state != IDLE`.

## Test plan

- Single request: req0 `{file_id=0xDABBAD00, offset=0x1000, len=0x00F}` with core model returning 16 bytes 0x00..0x0F -> `fr_*` match the request; 16 `rsp_valid[0]` strobes with data 0x00..0x0F; `rsp_valid[1]` never set; one `rq_done[0]` pulse; `busy` returns to 0.
- Round-robin: req0 and req1 held valid continuously with `len=3` -> grants alternate 0,1,0,1, starting with 0 after reset; each completion yields exactly 4 bytes to the correct requester.
- Length boundaries: `len=0` -> exactly 1 byte and `rq_done`; `len=0x7FF` -> exactly 2048 bytes, `cnt` reaches 0x800, then `rq_done`. Extra stray bytes after DONE -> no `rsp_valid`.
- Watchdog: `TIMEOUT=100`, core model stops after 5 of 8 bytes -> `rq_err[grant]` 101 cycles after the 5th byte and no `rq_done`. A byte arriving exactly at the timeout cycle -> no abort.
- Reset mid-stream: assert `rst` after 7 of 16 bytes -> all outputs 0 immediately; bytes arriving after release are dropped; the next grant goes to requester 0.
- Withdrawal and hold: req1 drops `rq_valid` while ISSUE runs for req0 -> req1 is never granted; the `fr_ready` delay of 5 cycles is honoured, with `fr_*` stable throughout ISSUE.
